spi_regfile: RTL and testbench
==============================

SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 Parameter NUM_REGS, 5, count of writable DATA_W-bit registers (1..128).
REQ-002 Parameter DATA_W, 8, register/data-phase width in bits (8..32).
REQ-003 Parameter SYNC_STAGES, 2, synchroniser depth on ncs/sclk/copi (2..4).
REQ-004 Port clk input 1 system clock; all state on rising edge.
REQ-005 Port rst_n input 1 asynchronous active-low reset.
REQ-006 Port ncs input 1 SPI chip select, active low, asynchronous to clk.
REQ-007 Port sclk input 1 SPI clock (mode 0), asynchronous to clk.
REQ-008 Port copi input 1 controller-out data, asynchronous to clk.
REQ-009 Port cipo output 1 controller-in data (read data, MSB first).
REQ-010 Port regs_out output NUM_REGS*DATA_W register contents, reg k at bits [k*DATA_W +: DATA_W].
REQ-011 Port wr_strobe output NUM_REGS one-clk pulse per register on commit.
REQ-012 Port frame_err output 1 sticky error flag; cleared by next valid frame.

Function
REQ-013 ncs, sclk, copi SHALL each pass SYNC_STAGES flops; edges detected from last two stages only.
REQ-014 Frame SHALL be FRAME_LEN = 8+DATA_W bits, MSB first: bit 1 = R/W (1 = write), 7 address bits, DATA_W data bits.
REQ-015 copi SHALL be sampled on each synchronised sclk rising edge while synchronised ncs is low.
REQ-016 FSM states IDLE, SHIFT, OVERRUN: IDLE->SHIFT on ncs falling edge (shift reg and bit counter cleared); SHIFT->OVERRUN on a rising sclk after FRAME_LEN bits; any state->IDLE on ncs rising edge.
REQ-017 Bit counter SHALL be $clog2(FRAME_LEN+1) bits wide and saturate at FRAME_LEN.
REQ-018 On ncs rising edge in SHIFT with exactly FRAME_LEN bits, write bit 1, address < NUM_REGS: target register SHALL update on the next clk and its wr_strobe bit SHALL pulse for exactly one clk.
REQ-019 Address >= NUM_REGS, read frames, and frames with write bit 0 SHALL not modify any register or strobe.
REQ-020 Short frame (<FRAME_LEN bits) or OVERRUN at ncs rise SHALL discard the frame and set frame_err; valid frame clears it.
REQ-021 ncs falling and rising edge in same clk (glitch) SHALL be treated as rising edge only.
REQ-022 sclk edges while ncs high SHALL be ignored.
REQ-023 regs_out SHALL be driven directly from register flops (no combinational path from SPI inputs).

Reset
REQ-024 rst_n low SHALL asynchronously clear all registers, synchronisers, shift register, counter, wr_strobe, frame_err, cipo to 0 and FSM to IDLE.
REQ-025 Reset mid-frame SHALL abort the frame with no register update; next frame starts clean on the next ncs falling edge.

Configuration
REQ-026 Macro SPI_REGFILE_READBACK_EN defined: after the 8th header bit of a read frame (R/W=0) with address < NUM_REGS, cipo SHALL present the addressed register MSB first, updating on each synchronised sclk falling edge; out-of-range address returns zeros.
REQ-027 Macro not defined: cipo SHALL be tied 0 and no read datapath flops SHALL exist.

Structure
REQ-028 Package spi_regfile_pkg SHALL hold FSM state enum, ADDR_W = 7, HDR_W = 8, and R/W bit encoding constants.
REQ-029 Sub-module spi_sync (parametrised depth, 1-bit, async reset) SHALL implement each synchroniser chain.

Verification
REQ-030 Write frame 1,0x02,0xA5 (DATA_W=8) -> reg2 = 0xA5, wr_strobe[2] one clk, others unchanged.
REQ-031 Write to address 0x05 with NUM_REGS=5 -> no register change, no strobe, frame_err = 0.
REQ-032 15-bit frame then 17-bit frame to reg0 -> reg0 unchanged, frame_err = 1; next valid write clears frame_err.
REQ-033 rst_n asserted after 9 bits of write to reg1 -> all outputs 0; subsequent full write 0x3C to reg1 -> reg1 = 0x3C.
REQ-034 READBACK_EN, reg4 = 0x96, read frame 0,0x04 -> cipo bits over data phase = 1,0,0,1,0,1,1,0.
REQ-035 DATA_W=16, NUM_REGS=2, sclk = clk/8: write 0xBEEF to reg1 -> regs_out[31:16] = 0xBEEF.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared constants and FSM encoding for the SPI register file.
package spi_regfile_pkg;

    localparam int   ADDR_W   = 7;     // address bits in the frame header
    localparam int   HDR_W    = 8;     // R/W bit + address
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_OVERRUN = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: single-bit synchroniser chain of STAGES flops (STAGES >= 2).
// o_tail exposes the last two stages so the caller can detect edges:
// o_tail[1] is the second-to-last stage, o_tail[0] the last stage.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_d,
    output logic [1:0] o_tail
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the chain; bit 0 is the first stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_tail = {r_sync[STAGES-2], r_sync[STAGES-1]};

endmodule

// File: rtl/spi_regfile.sv
// spi_regfile: SPI (mode 0) target exposing NUM_REGS writable registers.
// Frame = R/W bit, 7 address bits, DATA_W data bits, MSB first.
// Optional read-back on cipo is enabled by defining SPI_REGFILE_READBACK_EN;
// without it cipo is tied low and no read datapath exists.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ncs,
    input  logic                         sclk,
    input  logic                         copi,
    output logic                         cipo,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);

    localparam int FRAME_LEN = HDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic [1:0] w_ncs_tail;
    logic [1:0] w_sclk_tail;
    logic [1:0] w_copi_tail;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .i_d(ncs),  .o_tail(w_ncs_tail));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .i_d(sclk), .o_tail(w_sclk_tail));
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (.clk(clk), .rst_n(rst_n), .i_d(copi), .o_tail(w_copi_tail));

    // copi is sampled from the same stage that reveals the sclk edge, keeping
    // data and clock equally delayed; the last copi stage is not needed.
    logic w_copi;
    logic w_unused_copi;
    assign w_copi        = w_copi_tail[1];
    assign w_unused_copi = w_copi_tail[0];

    logic w_ncs_low;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_sclk_rise;
    logic w_sclk_fall;

    assign w_ncs_low   = ~w_ncs_tail[1];
    assign w_ncs_rise  =  w_ncs_tail[1] & ~w_ncs_tail[0];
    assign w_ncs_fall  = ~w_ncs_tail[1] &  w_ncs_tail[0];
    assign w_sclk_rise =  w_sclk_tail[1] & ~w_sclk_tail[0] & w_ncs_low;
    assign w_sclk_fall = ~w_sclk_tail[1] &  w_sclk_tail[0] & w_ncs_low;

    state_t                           r_state;
    logic [FRAME_LEN-1:0]             r_shift;
    logic [CNT_W-1:0]                 r_cnt;
    logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
    logic [NUM_REGS-1:0]              r_wr_strobe;
    logic                             r_frame_err;

    logic              w_frame_full;
    logic              w_rw;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_frame_full = (r_cnt == CNT_W'(FRAME_LEN));
    assign w_rw         = r_shift[FRAME_LEN-1];
    assign w_addr       = r_shift[FRAME_LEN-2 -: ADDR_W];
    assign w_data       = r_shift[DATA_W-1:0];

    // Frame FSM: collect bits, commit a complete write on ncs release.
    // ncs rise is checked first, so a same-cycle rise/fall pair acts as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_regs      <= '0;
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= '0;
            if (w_ncs_rise) begin
                r_state <= ST_IDLE;
                if (r_state == ST_SHIFT && w_frame_full) begin
                    r_frame_err <= 1'b0;
                    if (w_rw == RW_WRITE) begin
                        // Out-of-range addresses match no index and are dropped.
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (w_addr == ADDR_W'(k)) begin
                                r_regs[k]      <= w_data;
                                r_wr_strobe[k] <= 1'b1;
                            end
                        end
                    end
                end else if (r_state != ST_IDLE) begin
                    // Short frame or overrun; a release in IDLE (e.g. after
                    // a mid-frame reset) has no frame to judge.
                    r_frame_err <= 1'b1;
                end
            end else if (w_ncs_fall) begin
                r_state <= ST_SHIFT;
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_sclk_rise && r_state == ST_SHIFT) begin
                if (w_frame_full) begin
                    r_state <= ST_OVERRUN;
                end else begin
                    r_shift <= {r_shift[FRAME_LEN-2:0], w_copi};
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign regs_out  = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

`ifdef SPI_REGFILE_READBACK_EN
    logic              r_cipo;
    logic [DATA_W-1:0] r_rd_shift;
    logic [DATA_W-1:0] w_rd_word;

    // Register selected by the header address; zeros when out of range.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_shift[ADDR_W-1:0] == ADDR_W'(k)) w_rd_word = r_regs[k];
        end
    end

    // Read path: load after the header of a read frame, shift out on sclk falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cipo     <= 1'b0;
            r_rd_shift <= '0;
        end else if (w_ncs_rise || w_ncs_fall) begin
            r_cipo     <= 1'b0;
            r_rd_shift <= '0;
        end else if (w_sclk_fall && r_state == ST_SHIFT) begin
            if (r_cnt == CNT_W'(HDR_W) && r_shift[HDR_W-1] == RW_READ) begin
                r_cipo     <= w_rd_word[DATA_W-1];
                r_rd_shift <= w_rd_word << 1;
            end else begin
                r_cipo     <= r_rd_shift[DATA_W-1];
                r_rd_shift <= r_rd_shift << 1;
            end
        end
    end

    assign cipo = r_cipo;
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed + random frames against a frame-level model.
// Instance A uses the defaults (5 x 8-bit), instance B is 2 x 16-bit.
module tb_spi_regfile;

    localparam int NRA = 5, DWA = 8,  FLA = 16;
    localparam int NRB = 2, DWB = 16, FLB = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ncs_a = 1'b1, sclk_a = 1'b0, copi_a = 1'b0, cipo_a;
    logic ncs_b = 1'b1, sclk_b = 1'b0, copi_b = 1'b0, cipo_b;
    logic [NRA*DWA-1:0] regs_a;
    logic [NRB*DWB-1:0] regs_b;
    logic [NRA-1:0]     strb_a;
    logic [NRB-1:0]     strb_b;
    logic               err_a, err_b;

    always #5 clk = ~clk;

    spi_regfile #(.NUM_REGS(NRA), .DATA_W(DWA), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .ncs(ncs_a), .sclk(sclk_a), .copi(copi_a),
        .cipo(cipo_a), .regs_out(regs_a), .wr_strobe(strb_a), .frame_err(err_a));

    spi_regfile #(.NUM_REGS(NRB), .DATA_W(DWB), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .ncs(ncs_b), .sclk(sclk_b), .copi(copi_b),
        .cipo(cipo_b), .regs_out(regs_b), .wr_strobe(strb_b), .frame_err(err_b));

    // Running count of clk cycles each strobe bit was high.
    int unsigned tot_a [NRA] = '{default: 0};
    int unsigned tot_b [NRB] = '{default: 0};
    always @(posedge clk) begin
        for (int k = 0; k < NRA; k++) if (strb_a[k]) tot_a[k] <= tot_a[k] + 1;
        for (int k = 0; k < NRB; k++) if (strb_b[k]) tot_b[k] <= tot_b[k] + 1;
    end

    // Reference model: register contents and error flag per instance.
    logic [DWA-1:0] m_a [NRA];
    logic [DWB-1:0] m_b [NRB];
    logic           m_err_a, m_err_b;
    logic [39:0]    rd_bits;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NRA; k++) m_a[k] = '0;
        for (int k = 0; k < NRB; k++) m_b[k] = '0;
        m_err_a = 1'b0;
        m_err_b = 1'b0;
    endtask

    // Mode-0 transfer of n bits (MSB first); every step is a multiple of the
    // clk period from a falling clk edge, so sampling avoids rising edges.
    task automatic xfer(input int which, input logic [39:0] bits, input int n, input bit release_cs);
        @(negedge clk);
        if (which == 0) ncs_a = 1'b0; else ncs_b = 1'b0;
        #40;
        for (int i = 0; i < n; i++) begin
            if (which == 0) copi_a = bits[n-1-i]; else copi_b = bits[n-1-i];
            #39;
            rd_bits[i] = (which == 0) ? cipo_a : cipo_b;
            #1;
            if (which == 0) sclk_a = 1'b1; else sclk_b = 1'b1;
            #40;
            if (which == 0) sclk_a = 1'b0; else sclk_b = 1'b0;
        end
        #40;
        if (release_cs) begin
            if (which == 0) ncs_a = 1'b1; else ncs_b = 1'b1;
            #80;
        end
    endtask

    // Send one frame of n bits built from header/data, update the model and check.
    task automatic frame(input int which, input logic rw, input logic [6:0] addr,
                         input logic [15:0] data, input int n, input string tag);
        int          fl, nr, exp_k;
        logic [39:0] full, bits;
        logic [63:0] exp_regs;
        logic [7:0]  rd_obs, rd_exp;
        int unsigned snap [NRA];
        fl = (which == 0) ? FLA : FLB;
        nr = (which == 0) ? NRA : NRB;
        full = (which == 0) ? {24'd0, rw, addr, data[7:0]} : {16'd0, rw, addr, data};
        bits = (n <= fl) ? (full >> (fl - n)) : (full << (n - fl));
        for (int k = 0; k < NRA; k++) snap[k] = (which == 0) ? tot_a[k] : ((k < NRB) ? tot_b[k] : 0);

        xfer(which, bits, n, 1'b1);

        // Frame rules: exact length commits (writes in range), anything else errors.
        exp_k = -1;
        if (n == fl) begin
            if (which == 0) m_err_a = 1'b0; else m_err_b = 1'b0;
            if (rw && int'(addr) < nr) begin
                exp_k = int'(addr);
                if (which == 0) m_a[addr] = data[7:0]; else m_b[addr] = data;
            end
        end else begin
            if (which == 0) m_err_a = 1'b1; else m_err_b = 1'b1;
        end

        exp_regs = '0;
        if (which == 0) begin
            for (int k = 0; k < NRA; k++) exp_regs[k*DWA +: DWA] = m_a[k];
            chk({tag, "_regs"}, 64'(regs_a), exp_regs);
            chk({tag, "_err"},  64'(err_a),  64'(m_err_a));
            for (int k = 0; k < NRA; k++)
                chk($sformatf("%s_strb%0d", tag, k), 64'(tot_a[k] - snap[k]), 64'(k == exp_k));
            if (n == fl && !rw) begin
                for (int j = 0; j < 8; j++) rd_obs[7-j] = rd_bits[8+j];
`ifdef SPI_REGFILE_READBACK_EN
                rd_exp = (int'(addr) < NRA) ? m_a[addr] : 8'h00;
`else
                rd_exp = 8'h00;
`endif
                chk({tag, "_cipo"}, 64'(rd_obs), 64'(rd_exp));
            end
        end else begin
            for (int k = 0; k < NRB; k++) exp_regs[k*DWB +: DWB] = m_b[k];
            chk({tag, "_regs"}, 64'(regs_b), exp_regs);
            chk({tag, "_err"},  64'(err_b),  64'(m_err_b));
            for (int k = 0; k < NRB; k++)
                chk($sformatf("%s_strb%0d", tag, k), 64'(tot_b[k] - snap[k]), 64'(k == exp_k));
        end
    endtask

    initial begin
        model_reset();
        // Reset state.
        #1;
        chk("rst_regs_a", 64'(regs_a), 64'd0);
        chk("rst_regs_b", 64'(regs_b), 64'd0);
        chk("rst_strb_a", 64'(strb_a), 64'd0);
        chk("rst_err_a",  64'(err_a),  64'd0);
        chk("rst_cipo_a", 64'(cipo_a), 64'd0);
        #30;
        rst_n = 1'b1;
        #100;

        // Basic write to reg2.
        frame(0, 1'b1, 7'h02, 16'h00A5, FLA, "wr_r2");
        chk("wr_r2_val", 64'(regs_a[23:16]), 64'hA5);
        // Out-of-range address: ignored, no error.
        frame(0, 1'b1, 7'h05, 16'h0077, FLA, "wr_oob");
        // Read frame to a valid address: no change.
        frame(0, 1'b0, 7'h02, 16'h00FF, FLA, "rd_nowr");
        // Short frame then overrun to reg0.
        frame(0, 1'b1, 7'h00, 16'h0011, FLA - 1, "short");
        frame(0, 1'b1, 7'h00, 16'h0022, FLA + 1, "overrun");
        chk("overrun_err", 64'(err_a), 64'd1);
        frame(0, 1'b1, 7'h03, 16'h0033, FLA, "clr_err");

        // Reset in the middle of a write to reg1, with frame_err set.
        frame(0, 1'b1, 7'h01, 16'h0044, 5, "pre_rst");
        xfer(0, {24'd0, 1'b1, 7'h01, 8'h5A} >> (FLA - 9), 9, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_regs_a", 64'(regs_a), 64'd0);
        chk("mid_rst_regs_b", 64'(regs_b), 64'd0);
        chk("mid_rst_strb_a", 64'(strb_a), 64'd0);
        chk("mid_rst_err_a",  64'(err_a),  64'd0);
        chk("mid_rst_cipo_a", 64'(cipo_a), 64'd0);
        #30;
        rst_n = 1'b1;
        @(negedge clk);
        ncs_a = 1'b1;
        #100;
        chk("post_rst_err_a", 64'(err_a), 64'd0);
        frame(0, 1'b1, 7'h01, 16'h003C, FLA, "wr_r1");
        chk("wr_r1_val", 64'(regs_a[15:8]), 64'h3C);

        // Read-back of reg4.
        frame(0, 1'b1, 7'h04, 16'h0096, FLA, "wr_r4");
        frame(0, 1'b0, 7'h04, 16'h0000, FLA, "rd_r4");
        frame(0, 1'b0, 7'h06, 16'h0000, FLA, "rd_oob");

        // Wide instance, slow sclk.
        frame(1, 1'b1, 7'h01, 16'hBEEF, FLB, "b_beef");
        chk("b_beef_hi", 64'(regs_b[31:16]), 64'hBEEF);
        frame(1, 1'b1, 7'h00, 16'h1234, FLB - 3, "b_short");

        // Random frames on instance A.
        for (int it = 0; it < 24; it++) begin
            logic        rw;
            logic [6:0]  addr;
            logic [15:0] data;
            int          sel, n;
            rw   = ($urandom_range(0, 3) != 0);
            addr = 7'($urandom_range(0, 7));
            data = 16'($urandom);
            sel  = $urandom_range(0, 9);
            n    = (sel == 0) ? FLA - 1 : (sel == 1) ? FLA + 1 :
                   (sel == 2) ? $urandom_range(1, FLA - 2) : FLA;
            frame(0, rw, addr, data, n, $sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
